// File: rtl/nn_pkg.sv
// Shared types and helpers for the layer-to-layer streaming logic.
package nn_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // Counter width for n states, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_stream_serializer.sv
// Captures a layer's parallel activations on x_valid and replays them one per clock, neuron 0 first.
// Optional sticky drop flag `overrun` exists when LAYER_SER_OVERRUN_EN is defined.
module layer_stream_serializer
  import nn_pkg::*;
#(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           x_valid,
  input  logic [numNeuron*dataWidth-1:0] x_in,
  output logic [dataWidth-1:0]           data_out,
  output logic                           data_out_valid,
  output logic                           busy,
  output logic                           frame_done
`ifdef LAYER_SER_OVERRUN_EN
  ,
  output logic                           overrun
`endif
);

  localparam int                 CNT_W = clog2_min1(numNeuron);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(numNeuron - 1);

  ser_state_t                    state;
  ser_state_t                    state_nxt;
  logic [CNT_W-1:0]              cnt;
  logic [numNeuron*dataWidth-1:0] hold;
  logic                          shift;
  logic                          last;
  logic                          load;

  always_comb begin
    state_nxt = state;
    shift     = (state == SER_SHIFT);
    last      = shift && (cnt == LAST);
    // A strobe is taken only when idle or on the last beat; elsewhere it is dropped.
    load      = x_valid && (!shift || last);
    case (state)
      SER_IDLE:  if (x_valid) state_nxt = SER_SHIFT;
      SER_SHIFT: if (last && !x_valid) state_nxt = SER_IDLE;
      default:   state_nxt = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SER_IDLE;
    else     state <= state_nxt;
  end

  // Output stage: element cnt is registered while the counter advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      hold           <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      if (load) hold <= x_in;
      if (load || last) cnt <= '0;
      else if (shift)   cnt <= cnt + 1'b1;
      if (shift) data_out <= hold[cnt*dataWidth +: dataWidth];
      data_out_valid <= shift;
      frame_done     <= last;
    end
  end

  assign busy = data_out_valid;

`ifdef LAYER_SER_OVERRUN_EN
  logic drop;
  assign drop = x_valid && shift && !last;

  always_ff @(posedge clk) begin
    if (rst)       overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
  end
`endif

endmodule

// File: doc/layer_stream_serializer.md
# layer_stream_serializer

Sits between one neural-network layer and the next. It captures the parallel activation outputs of all `numNeuron` neurons of a layer in the cycle their common `outvalid` fires. It then replays them one per clock as a serial stream in the `myinput`/`myinputValid` format that each neuron of the following layer consumes. Output order is neuron 0 first. The stream is gapless, so the next layer's weight read address advances exactly `numNeuron` times per frame.

## Interface
Parameters:
- `numNeuron`, 30: neurons in the producing layer; number of beats per frame; must be ≥1.
- `dataWidth`, 16: activation width; matches the neuron `dataWidth`.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `x_valid`, in, 1: frame strobe; tied to the producing layer's `outvalid`; all neurons fire in the same cycle.
- `x_in`, in, `numNeuron*dataWidth`: packed activations; neuron k occupies `[k*dataWidth +: dataWidth]`.
- `data_out`, out, `dataWidth`: serial activation to the next layer's `myinput`.
- `data_out_valid`, out, 1: drives the next layer's `myinputValid`.
- `busy`, out, 1: high while a frame is being replayed.
- `frame_done`, out, 1: one-cycle pulse coincident with the last beat of each frame.
- `overrun`, out, 1: sticky drop flag. Present only with `LAYER_SER_OVERRUN_EN`.

## Operation
- States are IDLE and SHIFT.
- Internal storage:
  - holding register `numNeuron*dataWidth` wide;
  - beat counter `cnt`, width `$clog2(numNeuron)` with a minimum of 1.
- **Reset** (`rst`=1):
  - state goes to IDLE; `cnt`=0; holding register cleared.
  - `data_out`=0, `data_out_valid`=0, `busy`=0, `frame_done`=0, `overrun`=0.
  - Reset mid-frame abandons the frame. No further beats are emitted.
- **IDLE + `x_valid`=1**:
  - load holding register from `x_in`; `cnt`=0; go to SHIFT.
- **SHIFT**, every cycle:
  - register `data_out` = element `cnt`; `data_out_valid`=1; `cnt`++.
- **Last beat** (`cnt`==`numNeuron`-1):
  - `frame_done`=1.
  - With `x_valid`=0: return to IDLE.
  - With `x_valid`=1: reload the holding register, `cnt`=0, stay in SHIFT. The new frame's element 0 follows on the next cycle with no gap.
- **`x_valid`=1 in SHIFT on any non-last beat**:
  - the new frame is dropped; the current frame continues unaffected.
- **numNeuron=1**: every SHIFT beat is the last beat.
- **Data handling**: pure data movement, no arithmetic. Values pass bit-exact, signed or unsigned.

## Timing
- `x_valid` sampled high at edge T (IDLE) → `data_out_valid` high on cycles T+1 … T+numNeuron.
- `data_out` = neuron k during cycle T+1+k.
- `frame_done` high during cycle T+numNeuron.
- `busy` equals `data_out_valid`.
- Latency from strobe to first beat: 1 cycle. Throughput: one frame per `numNeuron` cycles when strobes are back-to-back on last beats.
- No backpressure: the consumer must accept every beat.
- `data_out` holds its last value when `data_out_valid`=0. Only the valid qualifies it.

## Configuration
- `LAYER_SER_OVERRUN_EN` defined:
  - `overrun` port exists.
  - It sets to 1 on any dropped frame (non-last-beat `x_valid` in SHIFT).
  - It stays set until `rst`.
- `LAYER_SER_OVERRUN_EN` not defined:
  - the port is absent and drops are silent.
  - Data behaviour is identical in both builds.
- The macro is defined or left undefined in the shared `include.v`.

## Structure
- Shared package `nn_pkg`: state encoding constants `SER_IDLE`=0 and `SER_SHIFT`=1, plus the `clog2`-with-minimum-1 helper.
- Single flat module, no sub-module. The element mux is an indexed part-select on the holding register. A shift-register implementation is equally acceptable if the timing above holds.

## Test plan
- **Basic order**: numNeuron=4, dataWidth=16, `x_in`={16'h0004,16'h0003,16'h0002,16'h0001}, `x_valid` pulse at T → `data_out` 1,2,3,4 on T+1..T+4; `frame_done` only at T+4; idle after.
- **Back-to-back**: second pulse with {8,7,6,5} at T+4 → beats 1,2,3,4,5,6,7,8 contiguous on T+1..T+8; `data_out_valid` never drops.
- **Drop**: second pulse at T+2 → stream stays 1,2,3,4, then idle. With macro, `overrun`=1 from T+3 until reset; without macro, no port.
- **Reset mid-frame**: `rst` at T+2 → `data_out_valid`=0 and `data_out`=0 from T+3; a fresh pulse at T+5 streams normally.
- **Single neuron**: numNeuron=1, `x_in`=16'h8000 pulsed on consecutive cycles → one beat of 16'h8000 per cycle; `frame_done` high every beat; no overrun.
- **Signed passthrough**: 16'hFFFF and 16'h7FFF emitted bit-exact in order.
